// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock, round keys
// expanded on the fly, valid/ready handshakes on plaintext and ciphertext sides.
module aes128_enc_iter #(
    parameter bit ZERO_ON_IDLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rcon);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h000000};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    fsm_t         fsm_r, fsm_next_s;
    logic [127:0] state_r, rk_r, rk_next_s, sr_s, round_out_s;
    logic [7:0]   rcon_r;
    logic [3:0]   round_r;
    logic         last_round_s;

    assign rk_next_s    = key_step(rk_r, rcon_r);
    assign sr_s         = shift_rows(sub_bytes(state_r));
    assign last_round_s = (round_r >= 4'd10);
    assign round_out_s  = (last_round_s ? sr_s : mix_columns(sr_s)) ^ rk_next_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r <= ST_IDLE;
        end else begin
            fsm_r <= fsm_next_s;
        end
    end

    // Next-state and handshake decode; unused encodings fall back to IDLE.
    always_comb begin
        fsm_next_s = fsm_r;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (fsm_r)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    fsm_next_s = ST_ROUND;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                busy = 1'b1;
                if (last_round_s) begin
                    fsm_next_s = ST_DONE;
                end else begin
                    fsm_next_s = ST_ROUND;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_next_s = ST_IDLE;
                end else begin
                    fsm_next_s = ST_DONE;
                end
            end
            default: begin
                fsm_next_s = ST_IDLE;
            end
        endcase
    end

    // Cipher datapath: load on accept, one round per cycle while in ROUND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= 128'h0;
            rk_r    <= 128'h0;
            rcon_r  <= 8'h01;
            round_r <= 4'd0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_r <= plaintext ^ key;
                        rk_r    <= key;
                        rcon_r  <= 8'h01;
                        round_r <= 4'd1;
                    end
                end
                ST_ROUND: begin
                    state_r <= round_out_s;
                    rk_r    <= rk_next_s;
                    rcon_r  <= xtime(rcon_r);
                    if (!last_round_s) begin
                        round_r <= round_r + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output mux: optionally blank the result bus while no block is offered.
    always_comb begin
        if (ZERO_ON_IDLE && (fsm_r != ST_DONE)) begin
            ciphertext = 128'h0;
        end else begin
            ciphertext = state_r;
        end
    end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Self-checking bench for aes128_enc_iter: known-answer vectors, handshake
// corner cases and random blocks against a byte-level AES reference model.
module tb_aes128_enc_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] plaintext = 128'h0;
    logic [127:0] key = 128'h0;
    logic         in_ready, out_valid, busy;
    logic [127:0] ciphertext;
    logic         in_ready0, out_valid0, busy0;
    logic [127:0] ciphertext0;

    int total = 0;
    int bad = 0;

    logic [7:0] sbox_m [256];

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CT3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_enc_iter #(.ZERO_ON_IDLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ciphertext), .busy(busy)
    );

    aes128_enc_iter #(.ZERO_ON_IDLE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .plaintext(plaintext), .key(key), .out_valid(out_valid0), .out_ready(out_ready),
        .ciphertext(ciphertext0), .busy(busy0)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, x, acc;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(v[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            end
            acc = inv; x = inv;
            for (int n = 0; n < 4; n++) begin
                x = {x[6:0], x[7]};
                acc = acc ^ x;
            end
            sbox_m[v] = acc ^ 8'h63;
        end
    endtask

    task automatic aes_model(input logic [127:0] pt, input logic [127:0] k,
                             output logic [127:0] ct, output logic [127:0] last_rk);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  st [4][4];
        logic [7:0]  tmp [4][4];
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]], sbox_m[t[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                st[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[r][c] = sbox_m[st[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10)
                        st[r][c] = gmul(8'h02, tmp[r][c]) ^ gmul(8'h03, tmp[(r+1)%4][c])
                                   ^ tmp[(r+2)%4][c] ^ tmp[(r+3)%4][c];
                    else
                        st[r][c] = tmp[r][c];
                    st[r][c] = st[r][c] ^ w[4*rnd+c][31-8*r -: 8];
                end
        end
        ct = 128'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ct[127-8*(r+4*c) -: 8] = st[r][c];
        last_rk = {w[40], w[41], w[42], w[43]};
    endtask

    // Present a block while IDLE; returns at the negedge after the accept edge.
    task automatic accept(input logic [127:0] pt, input logic [127:0] k);
        plaintext = pt; key = k; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Edges counted from the accept edge until out_valid, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (ciphertext !== 128'h0) begin bad++; $display("FAIL reset_ct got=%h want=0", ciphertext); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_vec1();
        int n;
        logic [127:0] exp, rk;
        aes_model(PT1, K1, exp, rk);
        total++; if (exp !== CT1) begin bad++; $display("FAIL model_vec1 got=%h want=%h", exp, CT1); end
        out_ready = 1'b1;
        accept(PT1, K1);
        wait_valid(n);
        total++; if (n !== 10) begin bad++; $display("FAIL vec1_latency got=%0d want=10", n); end
        total++; if (ciphertext !== exp) begin bad++; $display("FAIL vec1_ct got=%h want=%h", ciphertext, exp); end
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL vec1_in_ready got=%b want=1", in_ready); end
        total++; if (ciphertext !== 128'h0) begin bad++; $display("FAIL vec1_ct_idle got=%h want=0", ciphertext); end
    endtask

    task automatic test_vec2_rk();
        int n;
        logic [127:0] exp, rk;
        aes_model(PT2, K2, exp, rk);
        total++; if (rk !== RK2) begin bad++; $display("FAIL model_rk2 got=%h want=%h", rk, RK2); end
        out_ready = 1'b1;
        accept(PT2, K2);
        wait_valid(n);
        total++; if (ciphertext !== CT2) begin bad++; $display("FAIL vec2_ct got=%h want=%h", ciphertext, CT2); end
        total++; if (dut.rk_r !== rk) begin bad++; $display("FAIL vec2_final_rk got=%h want=%h", dut.rk_r, rk); end
        @(negedge clk);
    endtask

    task automatic test_hold_zero0();
        int n;
        out_ready = 1'b0;
        accept(128'h0, 128'h0);
        wait_valid(n);
        total++; if (n !== 10) begin bad++; $display("FAIL vec3_latency got=%0d want=10", n); end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b want=1", out_valid); end
            total++; if (ciphertext !== CT3) begin bad++; $display("FAIL hold_ct got=%h want=%h", ciphertext, CT3); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready got=%b want=0", in_ready); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b want=1", busy); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid0 !== 1'b0) begin bad++; $display("FAIL keep_valid0 got=%b want=0", out_valid0); end
        total++; if (ciphertext0 !== CT3) begin bad++; $display("FAIL keep_ct0 got=%h want=%h", ciphertext0, CT3); end
        total++; if (ciphertext !== 128'h0) begin bad++; $display("FAIL zero_ct got=%h want=0", ciphertext); end
    endtask

    task automatic test_back_to_back();
        int cyc, na, no;
        int at [2];
        int ot [2];
        logic [127:0] od [2];
        cyc = 0; na = 0; no = 0;
        out_ready = 1'b1;
        plaintext = PT1; key = K1; in_valid = 1'b1;
        while (no < 2 && cyc < 80) begin
            if (out_valid && no < 2) begin ot[no] = cyc; od[no] = ciphertext; no++; end
            if (in_ready && in_valid && na < 2) begin
                at[na] = cyc; na++;
            end else if (na == 1) begin
                plaintext = PT2; key = K2;
            end else if (na == 2) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        total++; if (no !== 2 || na !== 2) begin bad++; $display("FAIL b2b_counts got=%0d/%0d want=2/2", na, no); end
        if (no == 2 && na == 2) begin
            total++; if (at[1] - at[0] !== 12) begin bad++; $display("FAIL b2b_accept_gap got=%0d want=12", at[1]-at[0]); end
            total++; if (ot[1] - ot[0] !== 12) begin bad++; $display("FAIL b2b_out_gap got=%0d want=12", ot[1]-ot[0]); end
            total++; if (at[1] <= ot[0]) begin bad++; $display("FAIL b2b_order got=%0d want>%0d", at[1], ot[0]); end
            total++; if (od[0] !== CT1) begin bad++; $display("FAIL b2b_ct1 got=%h want=%h", od[0], CT1); end
            total++; if (od[1] !== CT2) begin bad++; $display("FAIL b2b_ct2 got=%h want=%h", od[1], CT2); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b1;
        accept(PT1, K1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", out_valid); end
        total++; if (ciphertext !== 128'h0) begin bad++; $display("FAIL rmid_ct got=%h want=0", ciphertext); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        accept(PT2, K2);
        wait_valid(n);
        total++; if (n !== 10) begin bad++; $display("FAIL rmid_latency got=%0d want=10", n); end
        total++; if (ciphertext !== CT2) begin bad++; $display("FAIL rmid_ct2 got=%h want=%h", ciphertext, CT2); end
        @(negedge clk);
        // Reset while a finished block is being offered.
        out_ready = 1'b0;
        accept(128'h0, 128'h0);
        wait_valid(n);
        total++; if (ciphertext0 !== CT3) begin bad++; $display("FAIL rdone_pre got=%h want=%h", ciphertext0, CT3); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rdone_valid got=%b want=0", out_valid); end
        total++; if (ciphertext0 !== 128'h0) begin bad++; $display("FAIL rdone_ct0 got=%h want=0", ciphertext0); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        int n, stall;
        logic [127:0] pt, k, exp, rk;
        for (int it = 0; it < 8; it++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            aes_model(pt, k, exp, rk);
            stall = $urandom_range(0, 3);
            out_ready = (stall == 0);
            accept(pt, k);
            wait_valid(n);
            total++; if (n !== 10) begin bad++; $display("FAIL rand_latency it=%0d got=%0d want=10", it, n); end
            total++; if (ciphertext !== exp) begin bad++; $display("FAIL rand_ct it=%0d got=%h want=%h", it, ciphertext, exp); end
            for (int s = 0; s < stall; s++) begin
                in_valid = 1'b1;
                @(negedge clk);
                total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL rand_stall it=%0d got=%b%b want=01", it, in_ready, out_valid); end
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_release it=%0d got=%b want=0", it, out_valid); end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_vec1();
        test_vec2_rk();
        test_hold_zero0();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
